// File: rtl/input_vector_pingpong_if.sv
// input_vector_pingpong_if: input beat stream and read-bank vector handshake bundle
interface input_vector_pingpong_if #(
    parameter int DATA_W = 16,
    parameter int N_IN   = 128,
    parameter int LANES  = 4,
    parameter int LEN_W  = $clog2(N_IN + 1)
);
    logic [LANES*DATA_W-1:0] s_data;
    logic                    s_valid;
    logic                    s_last;
    logic                    s_ready;
    logic [N_IN*DATA_W-1:0]  m_vec_bus;
    logic [LEN_W-1:0]        m_len;
    logic                    m_valid;
    logic                    m_ready;
    logic                    m_bank;
    logic                    vector_done;
    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_vec_bus, m_len, m_valid, m_bank, vector_done
    );
    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_vec_bus, m_len, m_valid, m_bank, vector_done
    );
endinterface

// File: rtl/input_vector_pingpong.sv
// input_vector_pingpong: two-bank vector assembler between the input stream and the MAC array
module input_vector_pingpong #(
    parameter int DATA_W = 16,
    parameter int N_IN   = 128,
    parameter int LANES  = 4
) (
    input logic                    clk,
    input logic                    rst,
    input_vector_pingpong_if.slave vec_if
);
    localparam int BEATS  = N_IN / LANES;
    localparam int LEN_W  = $clog2(N_IN + 1);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {FREE, FILLING, FULL} bank_st_t;

    bank_st_t           state_q [2];
    bank_st_t           state_d [2];
    logic [LEN_W-1:0]   len_q [2];
    logic [LEN_W-1:0]   len_d [2];
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  elem [2][N_IN];
    logic               accept, release_rd, last_beat;

    assign vec_if.s_ready     = state_q[wr_bank_q] != FULL;
    assign vec_if.m_valid     = state_q[rd_bank_q] == FULL;
    assign vec_if.m_len       = vec_if.m_valid ? len_q[rd_bank_q] : '0;
    assign vec_if.m_bank      = rd_bank_q;
    assign vec_if.vector_done = done_q;
    assign accept     = vec_if.s_valid && vec_if.s_ready;
    assign release_rd = vec_if.m_valid && vec_if.m_ready;
    assign last_beat  = vec_if.s_last || beat_q == BEAT_W'(BEATS - 1);

    // Bank bookkeeping: write side completes into wr_bank, read side frees rd_bank
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        beat_d    = beat_q;
        done_d    = 1'b0;
        if (accept) begin
            state_d[wr_bank_q] = last_beat ? FULL : FILLING;
            beat_d             = last_beat ? '0 : beat_q + 1'b1;
            if (last_beat) begin
                len_d[wr_bank_q] = LEN_W'((int'(beat_q) + 1) * LANES);
                wr_bank_d        = ~wr_bank_q;
                done_d           = 1'b1;
            end
        end
        if (release_rd) begin
            state_d[rd_bank_q] = FREE;
            len_d[rd_bank_q]   = '0;
            rd_bank_d          = ~rd_bank_q;
        end
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= '{FREE, FREE};
            len_q     <= '{default: '0};
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            beat_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            beat_q    <= beat_d;
            done_q    <= done_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar i = 0; i < N_IN; i++) begin : g_elem
            logic [DATA_W-1:0] e_q;
            // Element storage: written only by the beat that carries this element
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    e_q <= '0;
                else if (accept && wr_bank_q == 1'(b) && beat_q == BEAT_W'(i / LANES))
                    e_q <= vec_if.s_data[(i % LANES)*DATA_W +: DATA_W];
            end
            assign elem[b][i] = e_q;
        end
    end

    // Elements past the stored length read as zero so stale data never leaks out
    for (genvar i = 0; i < N_IN; i++) begin : g_out
        assign vec_if.m_vec_bus[i*DATA_W +: DATA_W] =
            (len_q[rd_bank_q] > LEN_W'(i)) ? elem[rd_bank_q][i] : '0;
    end
endmodule

// File: tb/tb_input_vector_pingpong.sv
// tb_input_vector_pingpong: scoreboard bench for the ping-pong vector buffer
module tb_input_vector_pingpong;
    localparam int DATA_W = 16;
    localparam int N_IN   = 8;
    localparam int LANES  = 4;
    localparam int LEN_W  = 4;
    localparam int BEATS  = N_IN / LANES;
    localparam int VW     = N_IN * DATA_W;
    localparam int SW     = LANES * DATA_W;

    typedef struct {
        logic [VW-1:0]    vec;
        logic [LEN_W-1:0] len;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb [$];
    logic [DATA_W-1:0] mbuf [N_IN];
    int mbeat = 0;
    int rd_exp = 0;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    input_vector_pingpong_if #(.DATA_W(DATA_W), .N_IN(N_IN), .LANES(LANES)) vif();
    input_vector_pingpong #(.DATA_W(DATA_W), .N_IN(N_IN), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .vec_if(vif)
    );

    function automatic logic [SW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic send(input logic [SW-1:0] d, input logic last);
        int n = 0;
        exp_t e;
        logic fin;
        vif.s_data = d; vif.s_valid = 1'b1; vif.s_last = last;
        while (vif.s_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            compared++; mismatched++;
            $display("FAIL send_timeout s_ready=%b required=1", vif.s_ready);
            vif.s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int k = 0; k < LANES; k++) mbuf[mbeat*LANES+k] = d[k*DATA_W +: DATA_W];
        fin = last || mbeat == BEATS - 1;
        if (fin) begin
            e.len = LEN_W'((mbeat + 1) * LANES);
            e.vec = '0;
            for (int i = 0; i < (mbeat + 1) * LANES; i++) e.vec[i*DATA_W +: DATA_W] = mbuf[i];
            sb.push_back(e);
            mbeat = 0;
        end else mbeat++;
        @(negedge clk);
        vif.s_valid = 1'b0; vif.s_last = 1'b0;
        compared++;
        if (vif.vector_done !== fin) begin
            mismatched++;
            $display("FAIL vector_done got=%b required=%b", vif.vector_done, fin);
        end
    endtask

    task automatic consume();
        int n = 0;
        exp_t e;
        while (vif.m_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100 || sb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL consume_wait m_valid=%b queued=%0d required=1", vif.m_valid, sb.size());
            return;
        end
        e = sb[0];
        compared++;
        if (vif.m_len !== e.len) begin
            mismatched++; $display("FAIL m_len got=%0d required=%0d", vif.m_len, e.len);
        end
        compared++;
        if (vif.m_vec_bus !== e.vec) begin
            mismatched++; $display("FAIL m_vec_bus got=%h required=%h", vif.m_vec_bus, e.vec);
        end
        compared++;
        if (vif.m_bank !== rd_exp[0]) begin
            mismatched++; $display("FAIL m_bank got=%b required=%b", vif.m_bank, rd_exp[0]);
        end
        vif.m_ready = 1'b1;
        @(posedge clk);
        void'(sb.pop_front());
        rd_exp ^= 1;
        @(negedge clk);
        vif.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        vif.s_data = '0; vif.s_valid = 1'b0; vif.s_last = 1'b0; vif.m_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared += 6;
        if (vif.s_ready !== 1'b1) begin mismatched++; $display("FAIL rst_s_ready got=%b required=1", vif.s_ready); end
        if (vif.m_valid !== 1'b0) begin mismatched++; $display("FAIL rst_m_valid got=%b required=0", vif.m_valid); end
        if (vif.m_len !== '0) begin mismatched++; $display("FAIL rst_m_len got=%0d required=0", vif.m_len); end
        if (vif.vector_done !== 1'b0) begin mismatched++; $display("FAIL rst_done got=%b required=0", vif.vector_done); end
        if (vif.m_bank !== 1'b0) begin mismatched++; $display("FAIL rst_m_bank got=%b required=0", vif.m_bank); end
        if (vif.m_vec_bus !== '0) begin mismatched++; $display("FAIL rst_vec got=%h required=0", vif.m_vec_bus); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send(pack4(1, 2, 3, 4), 1'b0);
        send(pack4(5, 6, 7, 8), 1'b0);
        compared++;
        if (vif.m_valid !== 1'b1) begin mismatched++; $display("FAIL basic_m_valid got=%b required=1", vif.m_valid); end
        consume();
    endtask

    task automatic test_pingpong();
        send(pack4(10, 11, 12, 13), 1'b0);
        send(pack4(14, 15, 16, 17), 1'b0);
        send(pack4(20, 21, 22, 23), 1'b0);
        send(pack4(24, 25, 26, 27), 1'b0);
        compared++;
        if (vif.s_ready !== 1'b0) begin mismatched++; $display("FAIL pingpong_stall got=%b required=0", vif.s_ready); end
        fork
            begin
                send(pack4(30, 31, 32, 33), 1'b0);
                send(pack4(34, 35, 36, 37), 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                consume(); consume(); consume();
            end
        join
    endtask

    task automatic test_early();
        for (int r = 0; r < 2; r++) begin
            send(pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b0);
            send(pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b0);
            consume();
        end
        send(pack4(9, 9, 9, 9), 1'b1);
        consume();
    endtask

    task automatic test_backpressure();
        send(pack4(40, 41, 42, 43), 1'b0);
        send(pack4(44, 45, 46, 47), 1'b0);
        send(pack4(50, 51, 52, 53), 1'b0);
        send(pack4(54, 55, 56, 57), 1'b0);
        vif.s_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            vif.s_data = SW'({$urandom, $urandom});
            vif.s_last = c[0];
            @(negedge clk);
            compared++;
            if (vif.s_ready !== 1'b0) begin mismatched++; $display("FAIL bp_s_ready cycle=%0d got=%b required=0", c, vif.s_ready); end
        end
        vif.s_valid = 1'b0; vif.s_last = 1'b0;
        consume();
        send(pack4(60, 61, 62, 63), 1'b0);
        send(pack4(64, 65, 66, 67), 1'b0);
        consume();
        consume();
    endtask

    task automatic test_simultaneous();
        send(pack4(70, 71, 72, 73), 1'b0);
        send(pack4(74, 75, 76, 77), 1'b0);
        send(pack4(80, 81, 82, 83), 1'b0);
        fork
            send(pack4(84, 85, 86, 87), 1'b0);
            consume();
        join
        compared += 3;
        if (vif.m_valid !== 1'b1) begin mismatched++; $display("FAIL simul_m_valid got=%b required=1", vif.m_valid); end
        if (vif.s_ready !== 1'b1) begin mismatched++; $display("FAIL simul_s_ready got=%b required=1", vif.s_ready); end
        if (vif.m_bank !== 1'b1) begin mismatched++; $display("FAIL simul_m_bank got=%b required=1", vif.m_bank); end
        consume();
    endtask

    task automatic test_async_reset();
        send(pack4(90, 91, 92, 93), 1'b0);
        #2 rst = 1'b1;
        #1;
        compared += 5;
        if (vif.s_ready !== 1'b1) begin mismatched++; $display("FAIL arst_s_ready got=%b required=1", vif.s_ready); end
        if (vif.m_valid !== 1'b0) begin mismatched++; $display("FAIL arst_m_valid got=%b required=0", vif.m_valid); end
        if (vif.m_len !== '0) begin mismatched++; $display("FAIL arst_m_len got=%0d required=0", vif.m_len); end
        if (vif.m_bank !== 1'b0) begin mismatched++; $display("FAIL arst_m_bank got=%b required=0", vif.m_bank); end
        if (vif.vector_done !== 1'b0) begin mismatched++; $display("FAIL arst_done got=%b required=0", vif.vector_done); end
        mbeat = 0; rd_exp = 0; sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(pack4(100, 101, 102, 103), 1'b0);
        send(pack4(104, 105, 106, 107), 1'b0);
        consume();
        repeat (3) begin
            @(negedge clk);
            compared++;
            if (vif.vector_done !== 1'b0) begin mismatched++; $display("FAIL arst_extra_done got=%b required=0", vif.vector_done); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pingpong();
        test_early();
        test_backpressure();
        test_simultaneous();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
